// File: rtl/nios_led_debug_host_pkg.sv
// Shared types and sizes for the Nios II debug-host virtual-JTAG sequencer.
package nios_led_debug_host_pkg;

    localparam int SR_W    = 38;
    localparam int IR_W    = 2;
    localparam int SDR_LEN = 38;
    localparam int CNT_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RSP  = 3'd5
    } host_state_e;

    typedef struct packed {
        logic rti;
        logic uir;
        logic cdr;
        logic sdr;
        logic udr;
    } strobes_t;

    // One-hot virtual-JTAG strobe set for a given state; RSP drives none.
    function automatic strobes_t decode_strobes(input host_state_e st);
        strobes_t s;
        s = '0;
        case (st)
            ST_IDLE: s.rti = 1'b1;
            ST_UIR:  s.uir = 1'b1;
            ST_CDR:  s.cdr = 1'b1;
            ST_SDR:  s.sdr = 1'b1;
            ST_UDR:  s.udr = 1'b1;
            ST_RSP:  s = '0;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/nios_led_debug_host_tckgen.sv
// Divided test clock: toggles every TCK_DIV clk cycles while run is high, parked low otherwise.
module nios_led_debug_host_tckgen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);

    logic [7:0] div_cnt_r;
    logic       tck_r;
    logic       wrap_s;

    // rise/fall flag the cycle whose closing edge moves tck high/low
    always_comb begin
        wrap_s = run && (div_cnt_r == 8'(TCK_DIV - 1));
        rise   = wrap_s && !tck_r;
        fall   = wrap_s && tck_r;
    end

    // Divider counter and tck register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r <= 8'd0;
            tck_r     <= 1'b0;
        end else if (!run) begin
            div_cnt_r <= 8'd0;
            tck_r     <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r <= 8'd0;
            tck_r     <= ~tck_r;
        end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
        end
    end

    assign tck = tck_r;

endmodule

// File: rtl/nios_led_nios2_gen2_0_cpu_debug_host.sv
// Debug host: turns one command (IR + 38-bit DR) into a UIR/CDR/SDR/UDR virtual-JTAG
// sequence against the CPU debug slave and returns the captured DR as a response.
module nios_led_nios2_gen2_0_cpu_debug_host
    import nios_led_debug_host_pkg::*;
#(
    parameter int TCK_DIV = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [SR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SR_W-1:0] rsp_data,
    output logic [IR_W-1:0] rsp_ir_out,
    output logic            vji_tck,
    output logic            vji_tdi,
    output logic            vji_cdr,
    output logic            vji_sdr,
    output logic            vji_udr,
    output logic            vji_uir,
    output logic            vji_rti,
    output logic [IR_W-1:0] vji_ir_in,
    input  logic            vji_tdo,
    input  logic [IR_W-1:0] vji_ir_out
);

    host_state_e      state_r;
    host_state_e      state_next_s;
    strobes_t         strb_next_s;
    logic             accept_s;
    logic             run_s;
    logic             rise_s;
    logic             fall_s;
    logic             shift_last_s;
    logic [SR_W-1:0]  sr_r;
    logic             tdo_smp_r;
    logic [CNT_W-1:0] shift_cnt_r;

    nios_led_debug_host_tckgen #(
        .TCK_DIV (TCK_DIV)
    ) u_tckgen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run_s),
        .tck     (vji_tck),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    // Next-state logic: phase changes happen on tck fall, except acceptance and consumption
    always_comb begin
        accept_s     = cmd_valid && cmd_ready;
        shift_last_s = (shift_cnt_r == CNT_W'(SDR_LEN - 1));
        run_s        = (state_r != ST_IDLE) && (state_r != ST_RSP);
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: if (accept_s) state_next_s = ST_UIR; else state_next_s = ST_IDLE;
            ST_UIR:  if (fall_s) state_next_s = ST_CDR; else state_next_s = ST_UIR;
            ST_CDR:  if (fall_s) state_next_s = ST_SDR; else state_next_s = ST_CDR;
            ST_SDR:  if (fall_s && shift_last_s) state_next_s = ST_UDR; else state_next_s = ST_SDR;
            ST_UDR:  if (fall_s) state_next_s = ST_RSP; else state_next_s = ST_UDR;
            ST_RSP:  if (rsp_ready) state_next_s = ST_IDLE; else state_next_s = ST_RSP;
            default: state_next_s = ST_IDLE;
        endcase
        strb_next_s = decode_strobes(state_next_s);
    end

    // State, registered strobes/handshakes, and the DR shift path
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_ir_out  <= '0;
            vji_tdi     <= 1'b0;
            vji_ir_in   <= '0;
            vji_rti     <= 1'b1;
            vji_uir     <= 1'b0;
            vji_cdr     <= 1'b0;
            vji_sdr     <= 1'b0;
            vji_udr     <= 1'b0;
            sr_r        <= '0;
            tdo_smp_r   <= 1'b0;
            shift_cnt_r <= '0;
        end else begin
            state_r   <= state_next_s;
            cmd_ready <= (state_next_s == ST_IDLE);
            rsp_valid <= (state_next_s == ST_RSP);
            {vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr} <= strb_next_s;

            if (accept_s) begin
                vji_ir_in <= cmd_ir;
                sr_r      <= cmd_dr;
            end else if ((state_r == ST_RSP) && (state_next_s == ST_IDLE)) begin
                vji_ir_in <= '0;
            end

            if ((state_r == ST_UIR) && rise_s) begin
                rsp_ir_out <= vji_ir_out;
            end

            if ((state_r == ST_SDR) && rise_s) begin
                tdo_smp_r <= vji_tdo;
            end

            // Bit 0 must be on tdi before the first SDR rise
            if ((state_r == ST_CDR) && fall_s) begin
                vji_tdi <= sr_r[0];
            end

            if ((state_r == ST_SDR) && fall_s) begin
                sr_r        <= {tdo_smp_r, sr_r[SR_W-1:1]};
                vji_tdi     <= sr_r[1];
                shift_cnt_r <= shift_last_s ? '0 : shift_cnt_r + CNT_W'(1);
            end

            if ((state_r == ST_UDR) && (state_next_s == ST_RSP)) begin
                rsp_data <= sr_r;
            end
        end
    end

endmodule
